// File: rtl/layer_act_reader.sv
// Streams one frame of NUM_WORDS activation words from a 1-cycle-latency BRAM to an AXI-Stream port.
// Optional TLAST output enabled by defining LAYER_ACT_READER_TLAST_EN.
module layer_act_reader #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned AWIDTH    = 13,
  parameter int unsigned NUM_WORDS = 8192
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              SyncSig_V,
  input  logic              SyncSig_V_ap_vld,
  output logic              SyncSig_V_ap_ack,
  output logic [AWIDTH-1:0] ActBuf_Data_address0,
  output logic              ActBuf_Data_ce0,
  input  logic [DWIDTH-1:0] ActBuf_Data_q0,
  output logic [DWIDTH-1:0] reluRes_V_V_TDATA,
  output logic              reluRes_V_V_TVALID,
  input  logic              reluRes_V_V_TREADY,
  output logic              frame_done
`ifdef LAYER_ACT_READER_TLAST_EN
  ,
  output logic              reluRes_V_V_TLAST
`endif
);

  typedef enum logic [2:0] {StIdle, StAck, StRead, StDrain, StDone} state_e;

  localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic              tok_q;
  logic [AWIDTH-1:0] cnt_q, addr_q;
  logic              rd_vld_q;
  logic [DWIDTH-1:0] fifo_data_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
`ifdef LAYER_ACT_READER_TLAST_EN
  logic              rd_last_q;
  logic [1:0]        fifo_last_q;
`endif

  logic       fifo_valid, push, pop, room, issue, ack, done;
  logic [2:0] occ_eff;

  assign fifo_valid = (count_q != 2'd0);
  assign push       = rd_vld_q;
  assign pop        = fifo_valid && reluRes_V_V_TREADY;
  // A pop this cycle frees a slot in time for the read issued now, giving 1 word/cycle.
  assign occ_eff    = {1'b0, count_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign room       = (occ_eff < 3'd2);

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle:  if (SyncSig_V_ap_vld) state_d = StAck;
      StAck: begin
        ack     = 1'b1;
        state_d = tok_q ? StRead : StIdle;
      end
      StRead: begin
        if (room) begin
          issue = 1'b1;
          if (cnt_q == LastAddr) state_d = StDrain;
        end
      end
      StDrain: if (!fifo_valid && !rd_vld_q) state_d = StDone;
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q        <= StIdle;
      tok_q          <= 1'b0;
      cnt_q          <= '0;
      addr_q         <= '0;
      rd_vld_q       <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
`ifdef LAYER_ACT_READER_TLAST_EN
      rd_last_q      <= 1'b0;
      fifo_last_q    <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      rd_vld_q <= issue;
      if (state_q == StIdle && SyncSig_V_ap_vld) tok_q <= SyncSig_V;
      if (issue) begin
        addr_q <= cnt_q;
        cnt_q  <= cnt_q + AWIDTH'(1);
      end else if (state_q == StDone) begin
        cnt_q <= '0;
      end
`ifdef LAYER_ACT_READER_TLAST_EN
      rd_last_q <= issue && (cnt_q == LastAddr);
      if (push) fifo_last_q[wr_ptr_q] <= rd_last_q;
`endif
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ActBuf_Data_q0;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Outputs are forced low while reset is held so they read 0 in the reset cycle itself.
  assign SyncSig_V_ap_ack     = ack && !ap_rst;
  assign ActBuf_Data_ce0      = issue && !ap_rst;
  assign ActBuf_Data_address0 = ap_rst ? '0 : (issue ? cnt_q : addr_q);
  assign reluRes_V_V_TVALID   = fifo_valid && !ap_rst;
  assign reluRes_V_V_TDATA    = reluRes_V_V_TVALID ? fifo_data_q[rd_ptr_q] : '0;
  assign frame_done           = done && !ap_rst;
`ifdef LAYER_ACT_READER_TLAST_EN
  assign reluRes_V_V_TLAST    = reluRes_V_V_TVALID && fifo_last_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_layer_act_reader.sv
// Directed bench for layer_act_reader: 8-word frames (u_dut) and a 1-word frame (u_dut1).
module tb_layer_act_reader;
  localparam int NW = 8;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic        vld, tok, ack, ce0, tvalid, tready, fdone;
  logic [12:0] addr;
  logic [15:0] q0, tdata;
  logic        vld1, tok1, ack1, ce01, tvalid1, tready1, fdone1;
  logic [12:0] addr1;
  logic [15:0] q01, tdata1;
`ifdef LAYER_ACT_READER_TLAST_EN
  logic        tlast, tlast1;
`endif

  layer_act_reader #(.DWIDTH(16), .AWIDTH(13), .NUM_WORDS(NW)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .SyncSig_V(tok), .SyncSig_V_ap_vld(vld), .SyncSig_V_ap_ack(ack),
    .ActBuf_Data_address0(addr), .ActBuf_Data_ce0(ce0), .ActBuf_Data_q0(q0),
    .reluRes_V_V_TDATA(tdata), .reluRes_V_V_TVALID(tvalid), .reluRes_V_V_TREADY(tready),
    .frame_done(fdone)
`ifdef LAYER_ACT_READER_TLAST_EN
    , .reluRes_V_V_TLAST(tlast)
`endif
  );

  layer_act_reader #(.DWIDTH(16), .AWIDTH(13), .NUM_WORDS(1)) u_dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .SyncSig_V(tok1), .SyncSig_V_ap_vld(vld1), .SyncSig_V_ap_ack(ack1),
    .ActBuf_Data_address0(addr1), .ActBuf_Data_ce0(ce01), .ActBuf_Data_q0(q01),
    .reluRes_V_V_TDATA(tdata1), .reluRes_V_V_TVALID(tvalid1), .reluRes_V_V_TREADY(tready1),
    .frame_done(fdone1)
`ifdef LAYER_ACT_READER_TLAST_EN
    , .reluRes_V_V_TLAST(tlast1)
`endif
  );

  // BRAM models: mem[i] = i + 0x100, one cycle read latency.
  always @(posedge ap_clk) begin
    if (ce0)  q0  <= 16'h0100 + {3'b000, addr};
    if (ce01) q01 <= 16'h0100 + {3'b000, addr1};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int n_ack, ack1_cyc, ack2_cyc, n_ce, first_ce, first_tv, n_acc, n_done, done_cyc;

  // Runs up to ncyc cycles; mode 1 drives TREADY as 1,0,0,1,0,0...; rearm raises a new token.
  task automatic run(input int ncyc, input int mode, input int rearm, input int stop_acc);
    logic        prev_v, prev_r, saw_ack;
    logic [15:0] prev_d;
    n_ack = 0; ack1_cyc = -1; ack2_cyc = -1; n_ce = 0; first_ce = -1; first_tv = -1;
    n_acc = 0; n_done = 0; done_cyc = -1;
    prev_v = 1'b0; prev_r = 1'b1; prev_d = '0;
    for (int i = 0; i < ncyc; i++) begin
      if (i == rearm) begin
        vld = 1'b1;
        tok = 1'b1;
      end
      tready = (mode == 1) ? ((i % 3) == 0) : 1'b1;
      @(negedge ap_clk);
      saw_ack = ack;
      if (ack) begin
        n_ack++;
        if (n_ack == 1) ack1_cyc = i;
        else ack2_cyc = i;
      end
      if (ce0) begin
        chk("addr_order", addr, n_ce % NW);
        if (first_ce < 0) first_ce = i;
        n_ce++;
      end
      if (prev_v && !prev_r) begin
        chk("stall_valid", tvalid, 1);
        chk("stall_data", tdata, prev_d);
      end
      if (tvalid && first_tv < 0) first_tv = i;
      if (tvalid && tready) begin
        chk("data_order", tdata, 16'h0100 + 16'(n_acc % NW));
`ifdef LAYER_ACT_READER_TLAST_EN
        chk("tlast", tlast, (n_acc % NW) == NW - 1);
`endif
        n_acc++;
      end
      chk("occupancy_le_2", (n_ce - n_acc) <= 2, 1);
      if (fdone) begin
        n_done++;
        done_cyc = i;
      end
      prev_v = tvalid; prev_r = tready; prev_d = tdata;
      @(posedge ap_clk); #1;
      if (saw_ack) vld = 1'b0;
      if (stop_acc >= 0 && n_acc >= stop_acc) break;
    end
    tready = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_ce0"}, ce0, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_done"}, fdone, 0);
  endtask

  task automatic step1();
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
  endtask

  initial begin
    vld = 0; tok = 0; tready = 1;
    vld1 = 0; tok1 = 0; tready1 = 1;
    repeat (2) @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    chk_zero("in_reset");
    @(posedge ap_clk); #1;
    ap_rst = 0;
    @(negedge ap_clk);
    chk_zero("after_reset");
    @(posedge ap_clk); #1;

    // Full-rate frame
    vld = 1; tok = 1;
    run(20, 0, -1, -1);
    chk("f1_n_ack", n_ack, 1);
    chk("f1_ack_cyc", ack1_cyc, 1);
    chk("f1_first_ce", first_ce, 2);
    chk("f1_first_tv", first_tv, 4);
    chk("f1_n_ce", n_ce, NW);
    chk("f1_n_acc", n_acc, NW);
    chk("f1_n_done", n_done, 1);
    chk("f1_done_cyc", done_cyc, 13);

    // Back-pressured frame
    vld = 1; tok = 1;
    run(60, 1, -1, -1);
    chk("bp_n_acc", n_acc, NW);
    chk("bp_n_ce", n_ce, NW);
    chk("bp_n_done", n_done, 1);

    // Null token
    vld = 1; tok = 0;
    run(10, 0, -1, -1);
    chk("null_n_ack", n_ack, 1);
    chk("null_n_ce", n_ce, 0);
    chk("null_first_tv", first_tv, -1);
    chk("null_n_done", n_done, 0);

    // Second token arrives during READ; held off until after DONE
    vld = 1; tok = 1;
    run(40, 0, 5, -1);
    chk("rearm_n_ack", n_ack, 2);
    chk("rearm_done1", done_cyc, 27);
    chk("rearm_ack2_cyc", ack2_cyc, 15);
    chk("rearm_n_acc", n_acc, 2 * NW);
    chk("rearm_n_done", n_done, 2);

    // Reset after 3 accepted words, then a fresh frame from address 0
    vld = 1; tok = 1;
    run(20, 0, -1, 3);
    chk("mid_n_acc", n_acc, 3);
    ap_rst = 1;
    @(negedge ap_clk);
    chk_zero("mid_rst");
    @(posedge ap_clk); #1;
    ap_rst = 0;
    @(negedge ap_clk);
    chk_zero("post_mid_rst");
    @(posedge ap_clk); #1;
    vld = 1; tok = 1;
    run(20, 0, -1, -1);
    chk("restart_ack_cyc", ack1_cyc, 1);
    chk("restart_first_ce", first_ce, 2);
    chk("restart_n_acc", n_acc, NW);
    chk("restart_n_done", n_done, 1);

    // Single-word frame
    vld1 = 1; tok1 = 1;
    @(negedge ap_clk);
    chk("w1_c0_ack", ack1, 0);
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    chk("w1_c1_ack", ack1, 1);
    @(posedge ap_clk); #1;
    vld1 = 0;
    @(negedge ap_clk);
    chk("w1_c2_ce0", ce01, 1);
    chk("w1_c2_addr", addr1, 0);
    step1();
    chk("w1_c3_ce0", ce01, 0);
    chk("w1_c3_tvalid", tvalid1, 0);
    step1();
    chk("w1_c4_tvalid", tvalid1, 1);
    chk("w1_c4_tdata", tdata1, 16'h0100);
`ifdef LAYER_ACT_READER_TLAST_EN
    chk("w1_c4_tlast", tlast1, 1);
`endif
    step1();
    chk("w1_c5_tvalid", tvalid1, 0);
    chk("w1_c5_done", fdone1, 0);
    step1();
    chk("w1_c6_done", fdone1, 1);
    step1();
    chk("w1_c7_done", fdone1, 0);
    chk("w1_c7_ce0", ce01, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
